// File: rtl/game_state_ctl_pkg.sv
// game_pkg: shared definitions for the rhythm-game flow controller.
// The state encodings are consumed bit-for-bit by the LED decoder and the
// display, so they must not be renumbered.
package game_pkg;

  localparam int STATE_W = 3;
  localparam int MISS_W  = 4;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE  = 3'b000,
    ST_PLAY  = 3'b001,
    ST_STOP  = 3'b010,
    ST_SCORE = 3'b011,
    ST_SPEED = 3'b100,
    ST_MISS  = 3'b101
  } state_t;

  // Miss counter increment that sticks at all-ones instead of wrapping.
  function automatic logic [MISS_W-1:0] miss_sat_inc(input logic [MISS_W-1:0] v);
    logic [MISS_W-1:0] r;
    if (v == {MISS_W{1'b1}}) begin
      r = v;
    end else begin
      r = v + MISS_W'(1);
    end
    return r;
  endfunction

endpackage

// File: rtl/game_state_ctl_hold_timer.sv
// hold_timer: counts tick_en pulses and flags the tick that reaches the
// terminal count. Shared by the MISS and SCORE hold intervals.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   clr        : synchronous clear (wins over a simultaneous tick)
//   tick_en    : timebase pulse to count
//   term       : terminal count for the current interval
//   expire     : high in the cycle whose tick completes the interval
module hold_timer #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         tick_en,
  input  logic [W-1:0] term,
  output logic         expire
);

  logic [W-1:0] cnt_r;

  // Tick counter; saturates so a long stay in a state cannot wrap it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r <= '0;
    end else if (clr) begin
      cnt_r <= '0;
    end else if (tick_en && (cnt_r != {W{1'b1}})) begin
      cnt_r <= cnt_r + W'(1);
    end
  end

  // The current tick counts, so compare the count it would produce.
  always_comb begin
    if (tick_en) begin
      expire = (({1'b0, cnt_r} + (W+1)'(1)) >= {1'b0, term});
    end else begin
      expire = 1'b0;
    end
  end

endmodule

// File: rtl/game_state_ctl.sv
// game_state_ctl: master game-flow FSM for the rhythm game.
// Turns button pulses and note-engine events into the 3-bit state word,
// tracks speed level and miss count, and times the MISS/SCORE holds.
// Optional build macro MISS_LIMIT_EN: a miss that brings miss_cnt up to
// MAX_MISS ends the game (straight to SCORE); otherwise misses only count.
// Ports:
//   clk, rst_n        : clock, asynchronous active-low reset
//   tick_en           : one-cycle timebase pulse
//   start_p, pause_p, speed_p : one-cycle button pulses
//   miss_p, song_end  : note-engine event pulses
//   state             : current state code (see game_pkg)
//   speed_lvl         : selected speed, zero-padded to 2 bits
//   miss_cnt          : misses this game, saturating at 15
//   state_chg         : high in the first cycle of every new state
module game_state_ctl
  import game_pkg::*;
#(
  parameter int SPEED_LEVELS = 4,
  parameter int MISS_TICKS   = 2,
  parameter int SCORE_TICKS  = 10,
  parameter int MAX_MISS     = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               tick_en,
  input  logic               start_p,
  input  logic               pause_p,
  input  logic               speed_p,
  input  logic               miss_p,
  input  logic               song_end,
  output logic [STATE_W-1:0] state,
  output logic [1:0]         speed_lvl,
  output logic [MISS_W-1:0]  miss_cnt,
  output logic               state_chg
);

  localparam int SPD_W    = (SPEED_LEVELS > 1) ? $clog2(SPEED_LEVELS) : 1;
  localparam int HOLD_MAX = (SCORE_TICKS > MISS_TICKS) ? SCORE_TICKS : MISS_TICKS;
  localparam int HOLD_W   = $clog2(HOLD_MAX + 1);
`ifdef MISS_LIMIT_EN
  localparam bit LIMIT_EN = 1'b1;
`else
  localparam bit LIMIT_EN = 1'b0;
`endif

  logic [STATE_W-1:0] state_r, state_nxt;
  logic [SPD_W-1:0]   spd_r, spd_nxt;
  logic [MISS_W-1:0]  miss_r, miss_nxt, miss_inc;
  logic               chg_r;
  logic               hold_clr, hold_restart, hold_expire, limit_hit;
  logic [HOLD_W-1:0]  hold_term;

  assign miss_inc  = miss_sat_inc(miss_r);
  // Only the miss that first reaches the limit ends the game.
  assign limit_hit = LIMIT_EN && (miss_inc == MISS_W'(MAX_MISS)) &&
                     (miss_r != MISS_W'(MAX_MISS));
  assign hold_term = (state_r == ST_SCORE) ? HOLD_W'(SCORE_TICKS) : HOLD_W'(MISS_TICKS);

  hold_timer #(.W(HOLD_W)) u_hold (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (hold_clr),
    .tick_en (tick_en),
    .term    (hold_term),
    .expire  (hold_expire)
  );

  // State and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
      spd_r   <= '0;
      miss_r  <= '0;
      chg_r   <= 1'b0;
    end else begin
      state_r <= state_nxt;
      spd_r   <= spd_nxt;
      miss_r  <= miss_nxt;
      chg_r   <= (state_nxt != state_r);
    end
  end

  // Next-state decode; each state lists its inputs in priority order.
  always_comb begin
    state_nxt    = state_r;
    hold_restart = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (start_p) state_nxt = ST_SPEED;
        else         state_nxt = state_r;
      end
      ST_SPEED: begin
        if (start_p) state_nxt = ST_PLAY;
        else         state_nxt = state_r;
      end
      ST_PLAY: begin
        if (song_end)     state_nxt = ST_SCORE;
        else if (miss_p)  state_nxt = limit_hit ? ST_SCORE : ST_MISS;
        else if (pause_p) state_nxt = ST_STOP;
        else              state_nxt = state_r;
      end
      ST_MISS: begin
        if (song_end) begin
          state_nxt = ST_SCORE;
        end else if (miss_p) begin
          state_nxt    = limit_hit ? ST_SCORE : ST_MISS;
          hold_restart = 1'b1;
        end else if (hold_expire) begin
          state_nxt = ST_PLAY;
        end else begin
          state_nxt = state_r;
        end
      end
      ST_STOP: begin
        if (start_p)      state_nxt = ST_IDLE;
        else if (pause_p) state_nxt = ST_PLAY;
        else              state_nxt = state_r;
      end
      ST_SCORE: begin
        if (start_p || hold_expire) state_nxt = ST_IDLE;
        else                        state_nxt = state_r;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Next values for the speed/miss registers and the hold-timer clear.
  always_comb begin
    spd_nxt  = spd_r;
    miss_nxt = miss_r;
    hold_clr = (state_nxt != state_r) || hold_restart;
    case (state_r)
      ST_SPEED: begin
        if (start_p) begin
          miss_nxt = '0;
        end else if (speed_p) begin
          if (spd_r == SPD_W'(SPEED_LEVELS - 1)) spd_nxt = '0;
          else                                   spd_nxt = spd_r + SPD_W'(1);
        end else begin
          spd_nxt = spd_r;
        end
      end
      ST_PLAY, ST_MISS: begin
        if (!song_end && miss_p) miss_nxt = miss_inc;
        else                     miss_nxt = miss_r;
      end
      default: begin
        spd_nxt  = spd_r;
        miss_nxt = miss_r;
      end
    endcase
  end

  assign state     = state_r;
  assign speed_lvl = 2'(spd_r);
  assign miss_cnt  = miss_r;
  assign state_chg = chg_r;

endmodule

// File: doc/game_state_ctl.md
Name: game_state_ctl

Overview:
- Master game-flow FSM for the rhythm-game project; produces the 3-bit state word consumed by the LED decoder, the display and the note engine.
- Converts one-cycle button pulses and note-engine events into state transitions.
- Tracks the selected speed level and the miss count, and times the MISS and SCORE hold intervals.

Parameters:
- SPEED_LEVELS, 4, number of selectable speeds; speed_lvl wraps modulo this value.
- MISS_TICKS, 2, tick_en pulses spent in MISS before returning to PLAY.
- SCORE_TICKS, 10, tick_en pulses spent in SCORE before auto-return to IDLE.
- MAX_MISS, 8, miss count that ends the game (used only with the optional feature).

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- tick_en  input  1  one-cycle timebase pulse (e.g. 10 Hz), synchronous to clk
- start_p  input  1  debounced one-cycle start/confirm pulse
- pause_p  input  1  debounced one-cycle pause/resume pulse
- speed_p  input  1  debounced one-cycle speed-step pulse
- miss_p  input  1  note-engine pulse: a note passed unhit
- song_end  input  1  note-engine pulse: last note consumed
- state  output  3  current game state: IDLE=000, PLAY=001, STOP=010, SCORE=011, SPEED=100, MISS=101
- speed_lvl  output  2  selected speed, 0..SPEED_LEVELS-1
- miss_cnt  output  4  misses in the current game, saturating at 15
- state_chg  output  1  one-cycle pulse in the first cycle of any new state

Behaviour:
- Reset is asynchronous on rst_n low: state=IDLE, speed_lvl=0, miss_cnt=0, state_chg=0, hold counter=0.
- All outputs are registered. An input pulse sampled at edge N appears as the new state after edge N; state_chg is high for that one cycle.
- Transitions (inputs not listed for a state are ignored):
  - IDLE: start_p -> SPEED.
  - SPEED: speed_p -> speed_lvl+1, wrapping from SPEED_LEVELS-1 to 0, state unchanged. start_p -> PLAY and clears miss_cnt to 0. If start_p and speed_p occur together, start wins and speed_lvl is unchanged.
  - PLAY, priority song_end > miss_p > pause_p:
    - song_end -> SCORE.
    - miss_p -> MISS, miss_cnt+1 (saturating).
    - pause_p -> STOP.
  - MISS:
    - The hold counter clears on entry and counts tick_en; at MISS_TICKS -> PLAY.
    - Another miss_p increments miss_cnt and restarts the hold counter.
    - song_end -> SCORE immediately.
    - pause_p is ignored.
  - STOP: pause_p -> PLAY. start_p -> IDLE (abort; speed_lvl and miss_cnt are kept). If both occur together, start_p wins.
  - SCORE: start_p -> IDLE. Otherwise, after SCORE_TICKS tick_en pulses -> IDLE.
- Hold counter:
  - Counts only tick_en cycles and clears on every state change.
  - A tick_en that arrives in the entry cycle counts as the first tick.
- Illegal state codes (110, 111) recover to IDLE on the next edge with state_chg=1.
- The speed_lvl register width is $clog2(SPEED_LEVELS) bits; the upper bits of the 2-bit port are zero-padded.

Optional Feature:
- Macro: MISS_LIMIT_EN.
- Defined: when a miss_p raises miss_cnt to MAX_MISS, in PLAY or MISS, the FSM goes directly to SCORE instead of entering or staying in MISS.
- Undefined: misses never end the game; the MAX_MISS parameter is unused.

Decomposition:
- Package game_pkg holds:
  - the six state encodings, shared bit-for-bit with the LED decoder and the display;
  - STATE_W=3;
  - a miss-counter width constant of 4.
- One natural sub-module, hold_timer: a tick_en counter with clear and a terminal-count compare input, instantiated once and shared by MISS and SCORE.

Test Plan:
- Reset mid-PLAY with miss_cnt=3 and speed_lvl=2: pull rst_n low asynchronously -> state=000, miss_cnt=0 and speed_lvl=0 immediately, before the next clk edge.
- speed_lvl wrap:
  - Sequence: start_p, then 5 speed_p, then start_p.
  - Each speed_p: speed_lvl steps 1,2,3,0,1 and state stays 100 throughout.
  - Final start_p: state=001 with state_chg high for exactly 1 cycle.
- Simultaneous events in PLAY:
  - song_end and miss_p in the same cycle -> state=011 and miss_cnt unchanged.
  - miss_p and pause_p in the same cycle -> state=101 and miss_cnt+1.
- MISS hold, MISS_TICKS=2:
  - Two tick_en pulses -> return to 001.
  - A second miss_p after the first tick restarts the hold: 2 further ticks are needed, and miss_cnt=2.
- With MISS_LIMIT_EN and MAX_MISS=8: the 8th miss_p in PLAY -> state=011 directly, never 101.
- Without MISS_LIMIT_EN: 20 misses -> miss_cnt saturates at 15 and play continues.
- SCORE timeout: SCORE_TICKS=10 tick_en pulses -> IDLE. Force an illegal code 111 -> IDLE on the next edge with state_chg=1.
